// File: rtl/mem2_load_unit_if.sv
// mem1 -> mem2 instruction bundle plus the DCache load response.
// master drives it (mem1 buffer / dcache), slave is mem2_load_unit.
interface mem2_load_unit_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_excp;
  logic                  in_mem_access;
  logic                  in_is_load;
  logic [1:0]            in_ld_type;
  logic                  in_ld_unsigned;
  logic [1:0]            in_addr_lo;
  logic                  in_wreg;
  logic [REG_ADDR_W-1:0] in_waddr;
  logic [DATA_W-1:0]     in_wdata;
  logic                  in_llbit_we;
  logic                  in_llbit_value;
  logic                  dcache_valid_i;
  logic [DATA_W-1:0]     dcache_data_i;

  modport master (
    output in_valid, in_excp, in_mem_access, in_is_load,
    output in_ld_type, in_ld_unsigned, in_addr_lo,
    output in_wreg, in_waddr, in_wdata,
    output in_llbit_we, in_llbit_value,
    output dcache_valid_i, dcache_data_i
  );

  modport slave (
    input in_valid, in_excp, in_mem_access, in_is_load,
    input in_ld_type, in_ld_unsigned, in_addr_lo,
    input in_wreg, in_waddr, in_wdata,
    input in_llbit_we, in_llbit_value,
    input dcache_valid_i, dcache_data_i
  );
endinterface

// File: rtl/mem2_load_unit.sv
// mem2 stage: waits for DCache load data, aligns/extends it, registers writeback.
// Optional stall counter enabled by defining MEM2_PERF_CNT_EN.
module mem2_load_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         advance,
  output logic                         advance_ready,
  mem2_load_unit_if.slave              io,
  output logic [2+REG_ADDR_W+DATA_W-1:0] data_forward_o,
  output logic                         wb_valid_o,
  output logic                         wb_excp_o,
  output logic                         wb_wreg_o,
  output logic [REG_ADDR_W-1:0]        wb_waddr_o,
  output logic [DATA_W-1:0]            wb_wdata_o,
  output logic                         wb_llbit_we_o,
  output logic                         wb_llbit_value_o,
  output logic [31:0]                  perf_stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] buf_q, buf_n;
  logic              ld_pending;
  logic              dv;
  logic              data_ready;
  logic              fwd_wreg;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] result;

  assign dv = io.dcache_valid_i;
  assign ld_pending = io.in_valid & ~io.in_excp
                    & io.in_mem_access & io.in_is_load;

  always_comb begin
    state_n = state;
    buf_n   = buf_q;
    if (flush) begin
      // still owed a response: swallow it before the next load
      state_n = (state == WAIT && !dv) ? DRAIN : IDLE;
      buf_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_pending && dv && !advance) begin
            state_n = HOLD;
            buf_n   = io.dcache_data_i;
          end else if (ld_pending && !dv) begin
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (dv && advance) begin
            state_n = IDLE;
          end else if (dv) begin
            state_n = HOLD;
            buf_n   = io.dcache_data_i;
          end
        end
        HOLD: begin
          if (advance) state_n = IDLE;
        end
        DRAIN: begin
          if (dv) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      buf_q <= '0;
    end else begin
      state <= state_n;
      buf_q <= buf_n;
    end
  end

  assign advance_ready = ~ld_pending | (state == HOLD)
                       | (dv & (state != DRAIN));
  assign data_ready = ~ld_pending | (state == HOLD) | dv;

  assign load_word = (state == HOLD) ? buf_q : io.dcache_data_i;
  assign shifted   = load_word >> {io.in_addr_lo, 3'b000};

  always_comb begin
    aligned = load_word;
    unique case (io.in_ld_type)
      2'b00: aligned = {{(DATA_W-8){~io.in_ld_unsigned & shifted[7]}},
                        shifted[7:0]};
      2'b01: aligned = {{(DATA_W-16){~io.in_ld_unsigned & shifted[15]}},
                        shifted[15:0]};
      default: aligned = load_word;
    endcase
  end

  assign result   = ld_pending ? aligned : io.in_wdata;
  assign fwd_wreg = io.in_valid & ~io.in_excp & io.in_wreg;
  assign data_forward_o = {fwd_wreg, data_ready, io.in_waddr, result};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o       <= 1'b0;
      wb_excp_o        <= 1'b0;
      wb_wreg_o        <= 1'b0;
      wb_waddr_o       <= '0;
      wb_wdata_o       <= '0;
      wb_llbit_we_o    <= 1'b0;
      wb_llbit_value_o <= 1'b0;
    end else if (flush) begin
      wb_valid_o       <= 1'b0;
      wb_excp_o        <= 1'b0;
      wb_wreg_o        <= 1'b0;
      wb_waddr_o       <= '0;
      wb_wdata_o       <= '0;
      wb_llbit_we_o    <= 1'b0;
      wb_llbit_value_o <= 1'b0;
    end else if (advance) begin
      wb_valid_o       <= io.in_valid;
      wb_excp_o        <= io.in_excp;
      wb_wreg_o        <= fwd_wreg;
      wb_waddr_o       <= io.in_waddr;
      wb_wdata_o       <= result;
      wb_llbit_we_o    <= io.in_valid & ~io.in_excp & io.in_llbit_we;
      wb_llbit_value_o <= io.in_llbit_value;
    end
  end

`ifdef MEM2_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (io.in_valid && !advance_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem2_load_unit.sv
// Directed bench for mem2_load_unit: vector table plus multi-cycle sequences.
// Perf expectations follow MEM2_PERF_CNT_EN.
module tb_mem2_load_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        advance;
  logic        advance_ready;
  logic [38:0] data_forward_o;
  logic        wb_valid_o;
  logic        wb_excp_o;
  logic        wb_wreg_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        wb_llbit_we_o;
  logic        wb_llbit_value_o;
  logic [31:0] perf_stall_cnt_o;

  mem2_load_unit_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  mem2_load_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .advance          (advance),
    .advance_ready    (advance_ready),
    .io               (bus.slave),
    .data_forward_o   (data_forward_o),
    .wb_valid_o       (wb_valid_o),
    .wb_excp_o        (wb_excp_o),
    .wb_wreg_o        (wb_wreg_o),
    .wb_waddr_o       (wb_waddr_o),
    .wb_wdata_o       (wb_wdata_o),
    .wb_llbit_we_o    (wb_llbit_we_o),
    .wb_llbit_value_o (wb_llbit_value_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic clr();
    flush                 = 1'b0;
    advance               = 1'b0;
    bus.in_valid          = 1'b0;
    bus.in_excp           = 1'b0;
    bus.in_mem_access     = 1'b0;
    bus.in_is_load        = 1'b0;
    bus.in_ld_type        = 2'b00;
    bus.in_ld_unsigned    = 1'b0;
    bus.in_addr_lo        = 2'b00;
    bus.in_wreg           = 1'b0;
    bus.in_waddr          = 5'd0;
    bus.in_wdata          = 32'd0;
    bus.in_llbit_we       = 1'b0;
    bus.in_llbit_value    = 1'b0;
    bus.dcache_valid_i    = 1'b0;
    bus.dcache_data_i     = 32'd0;
  endtask

  task automatic ld(input logic [1:0] ty, input logic uns,
                    input logic [1:0] lo);
    bus.in_valid       = 1'b1;
    bus.in_mem_access  = 1'b1;
    bus.in_is_load     = 1'b1;
    bus.in_ld_type     = ty;
    bus.in_ld_unsigned = uns;
    bus.in_addr_lo     = lo;
    bus.in_wreg        = 1'b1;
    bus.in_waddr       = 5'd7;
  endtask

  typedef struct {
    logic        is_load;
    logic [1:0]  ty;
    logic        uns;
    logic [1:0]  lo;
    logic [31:0] data;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];
  logic [31:0] p0;

  initial begin
    vt[0] = '{1'b1, 2'b10, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vt[1] = '{1'b1, 2'b00, 1'b0, 2'd3, 32'h80112233, 32'h0, 32'hFFFFFF80};
    vt[2] = '{1'b1, 2'b00, 1'b1, 2'd3, 32'h80112233, 32'h0, 32'h00000080};
    vt[3] = '{1'b1, 2'b00, 1'b0, 2'd0, 32'h80112233, 32'h0, 32'h00000033};
    vt[4] = '{1'b1, 2'b00, 1'b0, 2'd1, 32'h0000A500, 32'h0, 32'hFFFFFFA5};
    vt[5] = '{1'b1, 2'b01, 1'b1, 2'd2, 32'hABCD0000, 32'h0, 32'h0000ABCD};
    vt[6] = '{1'b1, 2'b01, 1'b0, 2'd2, 32'hABCD0000, 32'h0, 32'hFFFFABCD};
    vt[7] = '{1'b1, 2'b01, 1'b0, 2'd0, 32'h12348765, 32'h0, 32'hFFFF8765};
    vt[8] = '{1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h12345678, 32'h12345678};

    clr();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_valid", {63'd0, wb_valid_o}, 64'd0);
    chk("rst_wb_wdata", {32'd0, wb_wdata_o}, 64'd0);
    chk("rst_perf", {32'd0, perf_stall_cnt_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single-cycle responses with advance
    for (int i = 0; i < 9; i++) begin
      clr();
      ld(vt[i].ty, vt[i].uns, vt[i].lo);
      bus.in_is_load     = vt[i].is_load;
      bus.in_wdata       = vt[i].wdata;
      bus.dcache_valid_i = vt[i].is_load;
      bus.dcache_data_i  = vt[i].data;
      advance            = 1'b1;
      #1;
      chk($sformatf("v%0d_adv_ready", i), {63'd0, advance_ready}, 64'd1);
      chk($sformatf("v%0d_fwd", i), {25'd0, data_forward_o},
          {25'd0, 1'b1, 1'b1, 5'd7, vt[i].exp});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wb_wdata", i), {32'd0, wb_wdata_o},
          {32'd0, vt[i].exp});
      chk($sformatf("v%0d_wb_wreg", i), {63'd0, wb_wreg_o}, 64'd1);
      @(negedge clk);
    end

    // delayed response: LD.B then LD.BU
    for (int u = 0; u < 2; u++) begin
      clr();
      ld(2'b00, u[0], 2'd3);
      bus.dcache_data_i = 32'h80112233;
      for (int c = 0; c < 3; c++) begin
        #1;
        chk($sformatf("wait%0d_c%0d_adv_ready", u, c),
            {63'd0, advance_ready}, 64'd0);
        @(negedge clk);
      end
      bus.dcache_valid_i = 1'b1;
      advance            = 1'b1;
      #1;
      chk("wait_resp_adv_ready", {63'd0, advance_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("wait%0d_wb_wdata", u), {32'd0, wb_wdata_o},
          (u == 0) ? 64'h0000_0000_FFFF_FF80 : 64'h0000_0000_0000_0080);
      @(negedge clk);
    end

    // response without advance is buffered
    clr();
    ld(2'b01, 1'b1, 2'd2);
    bus.dcache_valid_i = 1'b1;
    bus.dcache_data_i  = 32'hABCD0000;
    @(negedge clk);
    bus.dcache_valid_i = 1'b0;
    bus.dcache_data_i  = 32'h0;
    #1;
    chk("hold_adv_ready", {63'd0, advance_ready}, 64'd1);
    chk("hold_fwd", {25'd0, data_forward_o},
        {25'd0, 1'b1, 1'b1, 5'd7, 32'h0000ABCD});
    @(negedge clk);
    advance = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_wb_wdata", {32'd0, wb_wdata_o}, 64'h0000ABCD);
    @(negedge clk);

    // flush while waiting: orphaned response dropped
    clr();
    ld(2'b10, 1'b0, 2'd0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_wb_valid", {63'd0, wb_valid_o}, 64'd0);
    @(negedge clk);
    clr();
    ld(2'b10, 1'b0, 2'd0);
    bus.dcache_valid_i = 1'b1;
    bus.dcache_data_i  = 32'h11111111;
    #1;
    chk("drain_adv_ready", {63'd0, advance_ready}, 64'd0);
    @(negedge clk);
    bus.dcache_valid_i = 1'b0;
    #1;
    chk("post_drain_adv_ready", {63'd0, advance_ready}, 64'd0);
    @(negedge clk);
    bus.dcache_valid_i = 1'b1;
    bus.dcache_data_i  = 32'h22222222;
    advance            = 1'b1;
    #1;
    chk("second_adv_ready", {63'd0, advance_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("flush_wb_wdata", {32'd0, wb_wdata_o}, 64'h22222222);
    @(negedge clk);

    // LL with exception
    clr();
    ld(2'b10, 1'b0, 2'd0);
    bus.in_excp        = 1'b1;
    bus.in_llbit_we    = 1'b1;
    bus.in_llbit_value = 1'b1;
    advance            = 1'b1;
    #1;
    chk("excp_adv_ready", {63'd0, advance_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("excp_wb_excp", {63'd0, wb_excp_o}, 64'd1);
    chk("excp_wb_wreg", {63'd0, wb_wreg_o}, 64'd0);
    chk("excp_wb_llbit_we", {63'd0, wb_llbit_we_o}, 64'd0);
    chk("excp_wb_valid", {63'd0, wb_valid_o}, 64'd1);
    @(negedge clk);

    // asynchronous reset while waiting
    clr();
    ld(2'b10, 1'b0, 2'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", {63'd0, wb_valid_o}, 64'd0);
    chk("arst_wb_excp", {63'd0, wb_excp_o}, 64'd0);
    chk("arst_perf", {32'd0, perf_stall_cnt_o}, 64'd0);
    @(negedge clk);
    clr();
    rst_n = 1'b1;
    @(negedge clk);
    ld(2'b10, 1'b0, 2'd0);
    bus.dcache_valid_i = 1'b1;
    bus.dcache_data_i  = 32'hCAFEF00D;
    advance            = 1'b1;
    #1;
    chk("arst_no_drain_adv_ready", {63'd0, advance_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("arst_wb_wdata", {32'd0, wb_wdata_o}, 64'hCAFEF00D);
    @(negedge clk);

    // five-cycle stall
    clr();
    p0 = perf_stall_cnt_o;
    ld(2'b10, 1'b0, 2'd0);
    repeat (5) @(negedge clk);
`ifdef MEM2_PERF_CNT_EN
    chk("perf_stall5", {32'd0, perf_stall_cnt_o - p0}, 64'd5);
`else
    chk("perf_tied0", {32'd0, perf_stall_cnt_o}, 64'd0);
`endif
    bus.dcache_valid_i = 1'b1;
    bus.dcache_data_i  = 32'h0BADF00D;
    advance            = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_wb_wdata", {32'd0, wb_wdata_o}, 64'h0BADF00D);
    @(negedge clk);
    clr();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
